// File: rtl/mips_pkg.sv
// Shared definitions for the MULT sequencer and HI/LO register pair.
package mips_pkg;

   localparam int MULT_ITERS         = 32;
   localparam int TIMEOUT_CYCLES_DEF = 40;

   typedef logic [1:0] mult_state_t;

   localparam mult_state_t ST_IDLE  = 2'd0;
   localparam mult_state_t ST_START = 2'd1;
   localparam mult_state_t ST_GUARD = 2'd2;
   localparam mult_state_t ST_WAIT  = 2'd3;

endpackage

// File: rtl/mult_hilo_ctrl_if.sv
// Bus between the MULT sequencer (master) and the Booth multiplier (slave).
interface mult_hilo_ctrl_if #(
   parameter int WIDTH = 32
);

   logic             mult_ctrl;
   logic [WIDTH-1:0] mult_a;
   logic [WIDTH-1:0] mult_b;
   logic [WIDTH-1:0] mult_hi_in;
   logic [WIDTH-1:0] mult_lo_in;
   logic             mult_fim;

   modport master (
      output mult_ctrl,
      output mult_a,
      output mult_b,
      input  mult_hi_in,
      input  mult_lo_in,
      input  mult_fim
   );

   modport slave (
      input  mult_ctrl,
      input  mult_a,
      input  mult_b,
      output mult_hi_in,
      output mult_lo_in,
      output mult_fim
   );

endinterface

// File: rtl/mult_hilo_ctrl_hilo_regs.sv
// HI/LO architectural register pair with independent write enables.
module hilo_regs #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             hi_we,
   input  logic [WIDTH-1:0] hi_d,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] lo_d,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   // Each half loads its own data when enabled, otherwise holds.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi <= '0;
         lo <= '0;
      end else begin
         if (hi_we) hi <= hi_d;
         if (lo_we) lo <= lo_d;
      end
   end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// MULT sequencer: launches the Booth multiplier, waits for fim, captures the
// product into HI/LO, serves MTHI/MTLO and interlocks the pipeline.
module mult_hilo_ctrl
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int WIDTH          = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             mult_req,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             mf_req,
   mult_hilo_ctrl_if.master mif,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             stall,
   output logic             timeout_err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   mult_state_t      state;
   logic [CW-1:0]    wait_cnt;
   logic [WIDTH-1:0] mult_a_q;
   logic [WIDTH-1:0] mult_b_q;
   logic             timeout_q;

   logic             capture;
   logic             mt_allowed;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] hi_d;
   logic [WIDTH-1:0] lo_d;

   // Sequencer: operand latch, load pulse, stale-fim guard, bounded wait.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         wait_cnt  <= '0;
         mult_a_q  <= '0;
         mult_b_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mult_req) begin
                  mult_a_q <= a_in;
                  mult_b_q <= b_in;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               state <= ST_GUARD;
            end
            ST_GUARD: begin
               wait_cnt <= '0;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mif.mult_fim) begin
                  state <= ST_IDLE;
               end else if (wait_cnt == CNT_LAST) begin
                  timeout_q <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // HI/LO write selection: product capture in WAIT, MT writes only in an idle cycle without a MULT.
   always_comb begin
      capture    = (state == ST_WAIT) && mif.mult_fim;
      mt_allowed = (state == ST_IDLE) && !mult_req;
      hi_we      = capture || (mt_allowed && mthi);
      lo_we      = capture || (mt_allowed && mtlo);
      hi_d       = capture ? mif.mult_hi_in : wdata;
      lo_d       = capture ? mif.mult_lo_in : wdata;
   end

   hilo_regs #(
      .WIDTH (WIDTH)
   ) u_hilo (
      .clk     (clk),
      .reset_n (reset_n),
      .hi_we   (hi_we),
      .hi_d    (hi_d),
      .lo_we   (lo_we),
      .lo_d    (lo_d),
      .hi      (hi_out),
      .lo      (lo_out)
   );

   assign mif.mult_ctrl = (state == ST_START);
   assign mif.mult_a    = mult_a_q;
   assign mif.mult_b    = mult_b_q;

   assign busy        = (state != ST_IDLE);
   assign stall       = busy && (mf_req || mult_req || mthi || mtlo);
   assign timeout_err = timeout_q;

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Sequencer and HI/LO register pair that sits directly downstream of the Booth multiplier (`MultControl`/`AFio`/`BFio` in; `MultHiFio`/`MultLoFio`/`fim` out).
- Accepts a MULT request from the main control unit, latches the operands and issues the one-cycle `MultControl` load pulse.
- Waits for `fim`, then captures the 64-bit product into HI/LO.
- Also serves MTHI/MTLO writes, feeds HI/LO to the MFHI/MFLO datapath mux, and raises a stall interlock while the multiplier is running.

Parameters:
- `TIMEOUT_CYCLES`, 40: maximum WAIT-state cycles before the operation is abandoned.
- `WIDTH`, 32: datapath width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `mult_req`  in  1  one-cycle MULT issue strobe from control.
- `a_in`  in  32  rs operand.
- `b_in`  in  32  rt operand.
- `mthi`  in  1  MTHI write strobe.
- `mtlo`  in  1  MTLO write strobe.
- `wdata`  in  32  MTHI/MTLO data.
- `mf_req`  in  1  MFHI/MFLO in decode this cycle.
- `mult_ctrl`  out  1  drives multiplier `MultControl`.
- `mult_a`  out  32  drives `AFio`.
- `mult_b`  out  32  drives `BFio`.
- `mult_hi_in`  in  32  from `MultHiFio`.
- `mult_lo_in`  in  32  from `MultLoFio`.
- `mult_fim`  in  1  from `fim`.
- `hi_out`  out  32  HI register.
- `lo_out`  out  32  LO register.
- `busy`  out  1  multiply in progress.
- `stall`  out  1  hold pipeline/control FSM.
- `timeout_err`  out  1  sticky error flag.

Behaviour:
- Reset (async, `reset_n`=0):
  - State goes to IDLE.
  - `hi_out`, `lo_out`, `mult_a`, `mult_b` go to 0.
  - `mult_ctrl`, `busy`, `stall`, `timeout_err` go to 0.
  - The wait counter goes to 0.
  - Reset mid-operation abandons the multiply. HI/LO become 0. The multiplier has no reset and is re-initialised by the next load pulse.
- States: IDLE, START, GUARD, WAIT.
- IDLE:
  - `mult_req`=1 latches `a_in`→`mult_a` and `b_in`→`mult_b`, then go to START.
  - Otherwise `mthi` writes `wdata` to HI and `mtlo` writes `wdata` to LO. Both may fire in the same cycle.
  - `mult_req` together with `mthi`/`mtlo` in the same cycle: `mult_req` wins and the MT writes are dropped.
- START:
  - `mult_ctrl`=1 for exactly this one cycle, decoded from the state register.
  - The multiplier loads and clears `fim` on the closing edge.
  - Go to GUARD.
- GUARD:
  - `mult_ctrl`=0.
  - `mult_fim` is ignored, to reject any stale high `fim` from the previous operation.
  - Clear the counter and go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - `mult_fim`=1: capture `mult_hi_in`→HI and `mult_lo_in`→LO on this edge, then go to IDLE.
  - Counter reaches `TIMEOUT_CYCLES` without `fim`: set `timeout_err` (sticky until reset), leave HI/LO unchanged, go to IDLE.
- Latency with the 32-iteration multiplier:
  - `mult_req` is sampled at edge E0.
  - `fim` goes high after E33.
  - HI/LO are updated at E34.
  - `busy` is high from after E0 through E34: 34 cycles.
- `busy` = (state != IDLE).
- `stall` = `busy` & (`mf_req` | `mult_req` | `mthi` | `mtlo`), combinational.
- Requests while `busy`:
  - `mult_req`, `mthi` and `mtlo` are ignored; control must hold them while `stall`.
  - `hi_out`/`lo_out` keep their old value until the capture edge.
- `mult_a`/`mult_b` stay stable from START until the next accepted `mult_req`.
- Back-to-back: `mult_req` in the first IDLE cycle after capture is accepted normally.
- Signedness: MULT only (two's-complement Booth). MULTU is not routed here.

Decomposition:
- Shared package `mips_pkg` holds:
  - the state encoding (IDLE=2'd0, START=2'd1, GUARD=2'd2, WAIT=2'd3);
  - `MULT_ITERS`=32;
  - the `TIMEOUT_CYCLES` default.
- One natural sub-module, `hilo_regs`: the HI/LO pair with its write-enable/data muxing. The FSM and counter stay in the top level.

Test Plan:
- Reset: hold `reset_n`=0 with random inputs → all outputs 0; release → IDLE, `busy`=0.
- MULT 7×6 with the real multiplier:
  - `busy`=1 for 34 cycles, then HI=0x00000000, LO=0x0000002A.
  - `mult_ctrl` high exactly one cycle.
- MULT 0x00010000×0x00010000 → HI=0x00000001, LO=0x00000000.
- Interlock:
  - `mthi` with `wdata`=0xDEADBEEF plus `mf_req` asserted mid-multiply → `stall`=1, HI unchanged, final HI equals the product.
  - After IDLE, `mthi` → HI=0xDEADBEEF.
- Timeout and stale `fim`: stub multiplier holds `fim`=1 through GUARD then 0 forever → stale `fim` ignored; after 40 WAIT cycles `timeout_err`=1, HI/LO unchanged, `busy`=0.
- Reset mid-operation: assert `reset_n`=0 at cycle 10 of WAIT → immediate IDLE, HI/LO=0; a new MULT 3×5 then gives LO=0x0000000F.
